vga_sb_console: RTL

//  System-bus initiator that turns a byte stream (e.g. UART RX) into text on the VGA peripheral.

---
 rtl/vga_console_pkg.sv | 28 ++
 rtl/vga_sb_console_if.sv | 14 +
 rtl/vga_console_cursor.sv | 63 ++++++
 rtl/vga_sb_console.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/vga_console_pkg.sv
// Shared constants for the VGA system-bus console: FSM state codes,
// control-code bytes and map offsets inside the VGA peripheral window.
// No logic; imported by the console top.
package vga_console_pkg;

  // FSM state codes
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_WCHAR    = 3'd1;
  localparam logic [2:0] ST_WCOL     = 3'd2;
  localparam logic [2:0] ST_CLR_CHAR = 3'd3;
  localparam logic [2:0] ST_CLR_COL  = 3'd4;

  // Control codes understood by the console
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_SPACE = 8'h20;

  // Map offsets from the peripheral base
  localparam logic [31:0] CHAR_MAP_OFFS = 32'h0000_0000;
  localparam logic [31:0] COL_MAP_OFFS  = 32'h0000_1000;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= 8'h20) && (c <= 8'h7E);
  endfunction

endpackage

// File: rtl/vga_sb_console_if.sv
// System-bus write port of the console (single byte-enabled writes).
// Zero latency: plain wires.
// Backpressure: initiator holds req/addr/be/wdata until gnt.
interface vga_sb_console_if;
  logic        req_o;
  logic        gnt_i;
  logic        we_o;
  logic [3:0]  be_o;
  logic [31:0] addr_o;
  logic [31:0] wdata_o;

  modport master (output req_o, we_o, be_o, addr_o, wdata_o, input gnt_i);
  modport slave  (input req_o, we_o, be_o, addr_o, wdata_o, output gnt_i);
endinterface

// File: rtl/vga_console_cursor.sv
// Text cursor: column/row counters with inc, newline, CR, backspace and home.
// Latency: outputs registered, new position visible the cycle after a control pulse.
// Backpressure: none; controls are single-cycle pulses from the console FSM.
module vga_console_cursor #(
  parameter int COLS  = 80,
  parameter int ROWS  = 30,
  parameter int COL_W = $clog2(COLS),
  parameter int ROW_W = $clog2(ROWS)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             i_inc,
  input  logic             i_nl,
  input  logic             i_cr,
  input  logic             i_dec,
  input  logic             i_home,
  output logic [COL_W-1:0] o_col,
  output logic [ROW_W-1:0] o_row,
  output logic [11:0]      o_idx,
  output logic [11:0]      o_nrow_base,
  output logic             o_col_last,
  output logic             o_col_zero
);

  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  logic [ROW_W-1:0] w_row_nxt;

  assign o_col_last  = (r_col == COL_W'(COLS - 1));
  assign o_col_zero  = (r_col == '0);
  assign w_row_nxt   = (r_row == ROW_W'(ROWS - 1)) ? '0 : r_row + 1'b1;
  assign o_idx       = 12'(r_row) * 12'(COLS) + 12'(r_col);
  // First cell of the row a newline would enter; used to seed the row clear.
  assign o_nrow_base = 12'(w_row_nxt) * 12'(COLS);
  assign o_col       = r_col;
  assign o_row       = r_row;

  // Cursor update; controls are mutually exclusive, home has priority.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_home) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_nl) begin
      r_col <= '0;
      r_row <= w_row_nxt;
    end else if (i_cr) begin
      r_col <= '0;
    end else if (i_dec) begin
      r_col <= r_col - 1'b1;
    end else if (i_inc) begin
      if (o_col_last) begin
        r_col <= '0;
        r_row <= w_row_nxt;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/vga_sb_console.sv
// Byte-stream to VGA text console; writes char and colour maps over the system bus.
// Latency: printable 3 cycles accept-to-accept with gnt held high, row clear adds 2*COLS.
// Backpressure: char_ready_o only in IDLE; bus stalls (gnt low) freeze outputs and state.
// Optional build macro VGA_CONSOLE_CLR_ON_RST_EN: leave reset already clearing the full screen.
module vga_sb_console
  import vga_console_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0700_0000,
  parameter int          COLS      = 80,
  parameter int          ROWS      = 30,
  parameter logic [7:0]  CLR_ATTR  = 8'h0F
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    char_valid_i,
  output logic                    char_ready_o,
  input  logic [7:0]              char_data_i,
  input  logic [7:0]              char_attr_i,
  output logic                    busy_o,
  output logic [$clog2(COLS)-1:0] cursor_col_o,
  output logic [$clog2(ROWS)-1:0] cursor_row_o,
  vga_sb_console_if.master        sb
);

  localparam logic [11:0] LAST_CELL = 12'(COLS * ROWS - 1);

  logic [2:0]  r_state;
  logic [7:0]  r_byte;
  logic [7:0]  r_attr;
  logic        r_adv;
  logic [11:0] r_clr_idx;
  logic [11:0] r_clr_end;

  logic        w_accept, w_req, w_gnt;
  logic        w_col_last, w_col_zero;
  logic [11:0] w_cur_idx, w_nrow_base, w_cell;
  logic [31:0] w_offs;
  logic [7:0]  w_byte;

  assign w_accept     = char_valid_i && (r_state == ST_IDLE);
  assign w_req        = (r_state != ST_IDLE);
  assign w_gnt        = w_req && sb.gnt_i;
  assign char_ready_o = (r_state == ST_IDLE);
  assign busy_o       = w_req;

  vga_console_cursor #(.COLS(COLS), .ROWS(ROWS)) u_cursor (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .i_inc       ((r_state == ST_WCOL) && w_gnt && r_adv),
    .i_nl        (w_accept && (char_data_i == CH_LF)),
    .i_cr        (w_accept && (char_data_i == CH_CR)),
    .i_dec       (w_accept && (char_data_i == CH_BS) && !w_col_zero),
    .i_home      (w_accept && (char_data_i == CH_FF)),
    .o_col       (cursor_col_o),
    .o_row       (cursor_row_o),
    .o_idx       (w_cur_idx),
    .o_nrow_base (w_nrow_base),
    .o_col_last  (w_col_last),
    .o_col_zero  (w_col_zero)
  );

  // Sequencer: byte decode in IDLE, then char/colour writes or a cell-clear walk.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
`ifdef VGA_CONSOLE_CLR_ON_RST_EN
      r_state   <= ST_CLR_CHAR;
      r_clr_end <= LAST_CELL;
`else
      r_state   <= ST_IDLE;
      r_clr_end <= '0;
`endif
      r_byte    <= '0;
      r_attr    <= '0;
      r_adv     <= 1'b0;
      r_clr_idx <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (is_printable(char_data_i)) begin
              r_byte  <= char_data_i;
              r_attr  <= char_attr_i;
              r_adv   <= 1'b1;
              r_state <= ST_WCHAR;
            end else if ((char_data_i == CH_BS) && !w_col_zero) begin
              // Cursor already stepped back this edge; blank the new cell.
              r_byte  <= CH_SPACE;
              r_attr  <= CLR_ATTR;
              r_adv   <= 1'b0;
              r_state <= ST_WCHAR;
            end else if (char_data_i == CH_LF) begin
              r_clr_idx <= w_nrow_base;
              r_clr_end <= w_nrow_base + 12'(COLS - 1);
              r_state   <= ST_CLR_CHAR;
            end else if (char_data_i == CH_FF) begin
              r_clr_idx <= '0;
              r_clr_end <= LAST_CELL;
              r_state   <= ST_CLR_CHAR;
            end
          end
        end
        ST_WCHAR: if (w_gnt) r_state <= ST_WCOL;
        ST_WCOL: begin
          if (w_gnt) begin
            if (r_adv && w_col_last) begin
              // Line wrap: clear the row the cursor moves into.
              r_clr_idx <= w_nrow_base;
              r_clr_end <= w_nrow_base + 12'(COLS - 1);
              r_state   <= ST_CLR_CHAR;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        ST_CLR_CHAR: if (w_gnt) r_state <= ST_CLR_COL;
        ST_CLR_COL: begin
          if (w_gnt) begin
            if (r_clr_idx == r_clr_end) begin
              r_state <= ST_IDLE;
            end else begin
              r_clr_idx <= r_clr_idx + 1'b1;
              r_state   <= ST_CLR_CHAR;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Bus payload select; purely from registered state so reset drops req at once.
  always_comb begin
    w_cell = w_cur_idx;
    w_offs = CHAR_MAP_OFFS;
    w_byte = r_byte;
    case (r_state)
      ST_WCOL: begin
        w_offs = COL_MAP_OFFS;
        w_byte = r_attr;
      end
      ST_CLR_CHAR: begin
        w_cell = r_clr_idx;
        w_byte = CH_SPACE;
      end
      ST_CLR_COL: begin
        w_cell = r_clr_idx;
        w_offs = COL_MAP_OFFS;
        w_byte = CLR_ATTR;
      end
      default: ;
    endcase
  end

  assign sb.req_o   = w_req;
  assign sb.we_o    = w_req;
  assign sb.be_o    = w_req ? (4'b0001 << w_cell[1:0]) : 4'h0;
  assign sb.addr_o  = w_req ? (BASE_ADDR + w_offs + {20'h0, w_cell}) : 32'h0;
  assign sb.wdata_o = w_req ? {4{w_byte}} : 32'h0;

endmodule
